// File: rtl/sal_ref_ctrl_if.sv
// ---------------------------------------------------------------------------
// sal_ref_ctrl_if
// Per-bank refresh handshake between the refresh manager and the bank
// controllers.
//   ref_req_o  [BK_CNT]  level request per bank, driven by the refresh manager
//   ref_gnt_i  [BK_CNT]  one-cycle pulse per bank once it has issued its REF
// Modports:
//   master  refresh manager side (drives ref_req_o, samples ref_gnt_i)
//   slave   bank controller side (samples ref_req_o, drives ref_gnt_i)
// ---------------------------------------------------------------------------
interface sal_ref_ctrl_if #(
   parameter int BK_CNT = 8
) ();
   logic [BK_CNT-1:0] ref_req_o;
   logic [BK_CNT-1:0] ref_gnt_i;

   modport master (output ref_req_o, input ref_gnt_i);
   modport slave  (input ref_req_o, output ref_gnt_i);
endinterface

// File: rtl/sal_ref_ctrl.sv
// ---------------------------------------------------------------------------
// sal_ref_ctrl
// Refresh manager for the SAL DDR controller. Generates tREFI-paced refresh
// obligations, tracks the owed refresh count (debt) and issues either an
// all-bank refresh or a round-robin per-bank refresh over the ref_req/ref_gnt
// handshake of the bank controllers.
//
// Ports:
//   clk          controller clock
//   rst_n        synchronous active-low reset
//   ref_en_i     refresh enable
//   pb_mode_i    0 = all-bank, 1 = per-bank round-robin (sampled in IDLE)
//   trefi_i      tREFI in clk cycles, 0 stops interval counting
//   ctrl_idle_i  no pending requests in decoder/bank queues
//   bus          refresh handshake (master modport: ref_req_o / ref_gnt_i)
//   urgent_o     debt at limit, scheduler must block new ACTs
//   debt_o       current refresh debt
//   ovf_o        sticky, a tick arrived while debt was already at the limit
//
// Build option:
//   SAL_REF_POSTPONE_EN  when defined, refreshes wait for ctrl_idle_i unless
//                        the debt has reached half the limit.
// ---------------------------------------------------------------------------
module sal_ref_ctrl #(
   parameter int BK_CNT   = 8,
   parameter int TREFI_W  = 16,
   parameter int MAX_DEBT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ref_en_i,
   input  logic               pb_mode_i,
   input  logic [TREFI_W-1:0] trefi_i,
   input  logic               ctrl_idle_i,
   sal_ref_ctrl_if.master     bus,
   output logic               urgent_o,
   output logic [3:0]         debt_o,
   output logic               ovf_o
);

   localparam int         PTR_W = $clog2(BK_CNT);
   localparam logic [3:0] MAX_D = 4'(MAX_DEBT);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t             r_state;
   logic [TREFI_W-1:0] r_cnt;
   logic [3:0]         r_debt;
   logic               r_urgent;
   logic               r_ovf;
   logic               r_pb;
   logic [PTR_W-1:0]   r_ptr;
   logic [BK_CNT-1:0]  r_target;
   logic [BK_CNT-1:0]  r_done;
   logic [BK_CNT-1:0]  r_req;

   logic [TREFI_W-1:0] w_shift;
   logic [TREFI_W-1:0] w_reload;
   logic               w_cnt_run;
   logic               w_tick;
   logic [BK_CNT-1:0]  w_done_nxt;
   logic               w_complete;
   logic               w_issue_cond;
   logic [BK_CNT-1:0]  w_new_target;
   logic [3:0]         w_debt_nxt;

   // Per-bank mode spreads one tREFI over all banks; a zero reload would
   // never tick, so it is forced to one.
   assign w_shift   = pb_mode_i ? (trefi_i >> PTR_W) : trefi_i;
   assign w_reload  = (w_shift == '0) ? TREFI_W'(1) : w_shift;
   assign w_cnt_run = ref_en_i && (trefi_i != '0);
   assign w_tick    = w_cnt_run && (r_cnt == TREFI_W'(1));

   // Grants only count for banks in the current target set.
   assign w_done_nxt = r_done | (bus.ref_gnt_i & r_target);
   assign w_complete = (r_state == S_REQ) && (w_done_nxt == r_target);

`ifdef SAL_REF_POSTPONE_EN
   assign w_issue_cond = (r_debt != 4'd0) &&
                         (ctrl_idle_i || (r_debt >= 4'(MAX_DEBT / 2)));
`else
   logic w_unused;
   assign w_unused     = ctrl_idle_i;
   assign w_issue_cond = (r_debt != 4'd0);
`endif

   assign w_new_target = pb_mode_i ? ({{(BK_CNT-1){1'b0}}, 1'b1} << r_ptr) : '1;

   // A tick and a completion in the same cycle cancel out; a tick at the
   // limit saturates. A completion implies debt >= 1 since issue needs debt.
   always_comb begin
      w_debt_nxt = r_debt;
      if (w_tick && !w_complete) begin
         if (r_debt != MAX_D) w_debt_nxt = r_debt + 4'd1;
      end else if (!w_tick && w_complete) begin
         w_debt_nxt = r_debt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= w_reload;
         r_debt   <= 4'd0;
         r_urgent <= 1'b0;
         r_ovf    <= 1'b0;
         r_pb     <= 1'b0;
         r_ptr    <= '0;
         r_target <= '0;
         r_done   <= '0;
         r_req    <= '0;
      end else begin
         if (w_cnt_run) r_cnt <= w_tick ? w_reload : (r_cnt - TREFI_W'(1));

         r_debt   <= w_debt_nxt;
         r_urgent <= (w_debt_nxt == MAX_D);
         if (w_tick && (r_debt == MAX_D)) r_ovf <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (ref_en_i && w_issue_cond) begin
                  r_state  <= S_REQ;
                  r_pb     <= pb_mode_i;
                  r_target <= w_new_target;
                  r_done   <= '0;
                  r_req    <= w_new_target;
               end
            end
            S_REQ: begin
               r_done <= w_done_nxt;
               r_req  <= r_target & ~w_done_nxt;
               if (w_complete) begin
                  r_state <= S_IDLE;
                  if (r_pb) r_ptr <= r_ptr + PTR_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ref_req_o = r_req;
   assign urgent_o      = r_urgent;
   assign debt_o        = r_debt;
   assign ovf_o         = r_ovf;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sal_ref_ctrl
// Self-checking bench for sal_ref_ctrl: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_sal_ref_ctrl;
   localparam int BK   = 8;
   localparam int TW   = 16;
   localparam int MAXD = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ref_en;
   logic          pb_mode;
   logic          ctrl_idle;
   logic [TW-1:0] trefi;
   logic          urgent;
   logic [3:0]    debt;
   logic          ovf;

   always #5 clk = ~clk;

   sal_ref_ctrl_if #(.BK_CNT(BK)) bus ();

   sal_ref_ctrl #(.BK_CNT(BK), .TREFI_W(TW), .MAX_DEBT(MAXD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ref_en_i   (ref_en),
      .pb_mode_i  (pb_mode),
      .trefi_i    (trefi),
      .ctrl_idle_i(ctrl_idle),
      .bus        (bus),
      .urgent_o   (urgent),
      .debt_o     (debt),
      .ovf_o      (ovf)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: cycles left until the next obligation, owed count,
   // and the set of banks still owed a REF in the refresh in flight.
   int          m_left;
   int          m_debt;
   int          m_next_bank;
   bit          m_ovf;
   bit          m_busy;
   bit          m_pb;
   logic [BK-1:0] m_owed;

   function automatic int reload_of(bit pb, int t);
      int r;
      r = pb ? (t / BK) : t;
      if (r == 0) r = 1;
      return r;
   endfunction

   function automatic logic [13:0] m_exp();
      logic [BK-1:0] rq;
      rq = m_busy ? m_owed : '0;
      return {rq, (m_debt == MAXD), 4'(m_debt), m_ovf};
   endfunction

   task automatic model_edge();
      bit tick, fin, go;
      if (!rst_n) begin
         m_debt = 0; m_ovf = 0; m_busy = 0; m_owed = '0; m_next_bank = 0; m_pb = 0;
         m_left = reload_of(pb_mode, int'(trefi));
         return;
      end
      tick = 0;
      if (ref_en && trefi != 0) begin
         if (m_left == 1) begin
            tick = 1;
            m_left = reload_of(pb_mode, int'(trefi));
         end else begin
            m_left--;
         end
      end
      fin = 0;
      if (m_busy) begin
         m_owed = m_owed & ~bus.ref_gnt_i;
         if (m_owed == '0) begin
            m_busy = 0;
            fin = 1;
            if (m_pb) m_next_bank = (m_next_bank + 1) % BK;
         end
      end else begin
         go = ref_en && (m_debt > 0);
`ifdef SAL_REF_POSTPONE_EN
         go = go && (ctrl_idle || (m_debt >= MAXD / 2));
`endif
         if (go) begin
            m_busy = 1;
            m_pb = pb_mode;
            if (pb_mode) begin
               m_owed = '0;
               m_owed[m_next_bank] = 1'b1;
            end else begin
               m_owed = '1;
            end
         end
      end
      if (tick && m_debt == MAXD) m_ovf = 1;
      m_debt = m_debt + int'(tick) - int'(fin);
      if (m_debt > MAXD) m_debt = MAXD;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit pb, input int t);
      rst_n = 1'b0; ref_en = 1'b1; pb_mode = pb; trefi = TW'(t);
      ctrl_idle = 1'b1; bus.ref_gnt_i = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b0, 100);
      checks++; if (bus.ref_req_o !== 8'h00) begin errors++; $display("FAIL reset_req got=%h exp=00", bus.ref_req_o); end
      checks++; if (urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent got=%b exp=0", urgent); end
      checks++; if (debt !== 4'd0) begin errors++; $display("FAIL reset_debt got=%0d exp=0", debt); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
   endtask

   task automatic test_allbank();
      int age = 0, rises = 0, last = -1, maxd = 0;
      logic [BK-1:0] prev = '0;
      do_reset(1'b0, 100);
      for (int cyc = 1; cyc <= 350; cyc++) begin
         step();
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL allbank_model cyc=%0d got=%h exp=%h", cyc, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
         if (bus.ref_req_o != 0 && prev == 0) begin
            rises++;
            checks++; if (bus.ref_req_o !== 8'hFF) begin errors++; $display("FAIL allbank_req got=%h exp=ff", bus.ref_req_o); end
            if (last >= 0) begin
               checks++; if (cyc - last != 100) begin errors++; $display("FAIL allbank_period got=%0d exp=100", cyc - last); end
            end
            last = cyc;
         end
         prev = bus.ref_req_o;
         if (int'(debt) > maxd) maxd = int'(debt);
         age = (bus.ref_req_o != 0) ? age + 1 : 0;
         bus.ref_gnt_i = (age == 3) ? bus.ref_req_o : '0;
      end
      bus.ref_gnt_i = '0;
      checks++; if (rises != 3) begin errors++; $display("FAIL allbank_count got=%0d exp=3", rises); end
      checks++; if (last != 301) begin errors++; $display("FAIL allbank_last_rise got=%0d exp=301", last); end
      checks++; if (maxd != 1) begin errors++; $display("FAIL allbank_maxdebt got=%0d exp=1", maxd); end
   endtask

   task automatic test_perbank();
      int rises = 0, n = 0;
      logic [BK-1:0] prev = '0;
      logic [BK-1:0] exp_oh;
      do_reset(1'b1, 800);
      while (rises < 9 && n < 1100) begin
         step();
         n++;
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL perbank_model cyc=%0d got=%h exp=%h", n, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
         if (bus.ref_req_o != 0 && prev == 0) begin
            rises++;
            exp_oh = 8'h01 << ((rises - 1) % 8);
            checks++; if (bus.ref_req_o !== exp_oh) begin errors++; $display("FAIL perbank_order n=%0d got=%h exp=%h", rises, bus.ref_req_o, exp_oh); end
         end
         prev = bus.ref_req_o;
         bus.ref_gnt_i = bus.ref_req_o;
      end
      bus.ref_gnt_i = '0;
      checks++; if (rises != 9) begin errors++; $display("FAIL perbank_count got=%0d exp=9", rises); end
   endtask

   task automatic test_overflow();
      do_reset(1'b0, 10);
      for (int i = 1; i <= 90; i++) begin
         step();
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL ovf_model cyc=%0d got=%h exp=%h", i, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
         if (i == 79) begin
            checks++; if (debt !== 4'd7 || urgent !== 1'b0) begin errors++; $display("FAIL ovf_c79 got=%0d/%b exp=7/0", debt, urgent); end
         end
         if (i == 80) begin
            checks++; if (debt !== 4'd8 || urgent !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_c80 got=%0d/%b/%b exp=8/1/0", debt, urgent, ovf); end
         end
         if (i == 90) begin
            checks++; if (debt !== 4'd8 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_c90 got=%0d/%b exp=8/1", debt, ovf); end
         end
      end
   endtask

   task automatic test_staggered();
      int n = 0;
      logic [BK-1:0] exp_rq;
      do_reset(1'b0, 100);
      while (bus.ref_req_o == 0 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (bus.ref_req_o == 0) begin errors++; $display("FAIL stag_wait got=timeout exp=req"); end
      for (int k = 1; k <= 12; k++) begin
         case (k)
            5:       bus.ref_gnt_i = 8'h01;
            7:       bus.ref_gnt_i = 8'hF6;
            8:       bus.ref_gnt_i = 8'h01;
            9:       bus.ref_gnt_i = 8'h08;
            11:      bus.ref_gnt_i = 8'hFF;
            default: bus.ref_gnt_i = 8'h00;
         endcase
         step();
         exp_rq = 8'hFF;
         if (k >= 5) exp_rq = exp_rq & ~8'h01;
         if (k >= 7) exp_rq = exp_rq & ~8'hF6;
         if (k >= 9) exp_rq = exp_rq & ~8'h08;
         checks++; if (bus.ref_req_o !== exp_rq) begin errors++; $display("FAIL stag_req c=%0d got=%h exp=%h", k, bus.ref_req_o, exp_rq); end
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL stag_model c=%0d got=%h exp=%h", k, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
      end
      bus.ref_gnt_i = '0;
      checks++; if (debt !== 4'd0) begin errors++; $display("FAIL stag_debt got=%0d exp=0", debt); end
   endtask

   task automatic test_reset_mid_req();
      do_reset(1'b0, 10);
      for (int i = 0; i < 30; i++) step();
      checks++; if (debt !== 4'd3 || bus.ref_req_o !== 8'hFF) begin errors++; $display("FAIL rstmid_pre got=%0d/%h exp=3/ff", debt, bus.ref_req_o); end
      rst_n = 1'b0;
      trefi = TW'(20);
      step();
      checks++; if ({bus.ref_req_o, urgent, debt, ovf} !== 14'h0) begin errors++; $display("FAIL rstmid_clear got=%h exp=0000", {bus.ref_req_o, urgent, debt, ovf}); end
      rst_n = 1'b1;
      for (int i = 1; i <= 39; i++) begin
         step();
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", i, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
      end
      bus.ref_gnt_i = 8'hFF;
      step();
      bus.ref_gnt_i = '0;
      checks++; if (debt !== 4'd1 || bus.ref_req_o !== 8'h00) begin errors++; $display("FAIL tick_and_done got=%0d/%h exp=1/00", debt, bus.ref_req_o); end
      step();
      checks++; if (bus.ref_req_o !== 8'hFF) begin errors++; $display("FAIL reissue got=%h exp=ff", bus.ref_req_o); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         ref_en = ($urandom_range(0, 19) != 0);
         ctrl_idle = $urandom_range(0, 1) == 1;
         if (i % 300 == 0) begin
            pb_mode = $urandom_range(0, 1) == 1;
            trefi = ($urandom_range(0, 5) == 0) ? TW'(0) : TW'($urandom_range(4, 60));
         end
         bus.ref_gnt_i = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         step();
         checks++;
         if ({bus.ref_req_o, urgent, debt, ovf} !== m_exp()) begin
            errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, {bus.ref_req_o, urgent, debt, ovf}, m_exp());
         end
      end
      bus.ref_gnt_i = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; ref_en = 1'b0; pb_mode = 1'b0; ctrl_idle = 1'b1;
      trefi = '0; bus.ref_gnt_i = '0;
      test_reset();
      test_allbank();
      test_perbank();
      test_overflow();
      test_staggered();
      test_reset_mid_req();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
